// File: rtl/push_key_encoder_if.sv
// rtl/push_key_encoder_if.sv - key-code token handshake between the encoder and the calculator core
interface push_key_encoder_if;
  logic [3:0] o_key_code;
  logic       o_key_valid;
  logic       i_key_ready;

  modport master (output o_key_code, output o_key_valid, input i_key_ready);
  modport slave  (input o_key_code, input o_key_valid, output i_key_ready);
endinterface

// File: rtl/push_key_encoder.sv
// rtl/push_key_encoder.sv - synchronize, debounce and encode 12 push switches into a 4-deep key-code FIFO
// Optional auto-repeat of a single held key is built when KEY_REPEAT_EN is defined.
module push_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          i_sw_push,
  push_key_encoder_if.master   key,
  output logic                 o_key_ovf,
  output logic                 o_key_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);

  logic [11:0]   sync1, sync2;
  logic [11:0]   deb, deb_prev;
  logic [CW-1:0] db_cnt;
  logic          sync_chg;

  logic [11:0]   rise;
  logic          evt;
  logic [3:0]    evt_code;

  logic [3:0]    mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          full, pop, push_ok;

  // Lowest key code wins; key code k lives on switch bit 11-k.
  function automatic logic [3:0] first_code(input logic [11:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 11; k >= 0; k--) begin
      if (v[11-k]) c = 4'(k);
    end
    return c;
  endfunction

  // The load fires on the edge where the counter steps into its saturated value.
  assign sync_chg = (sync1 != sync2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      db_cnt   <= '0;
    end else begin
      sync1    <= i_sw_push;
      sync2    <= sync1;
      deb_prev <= deb;
      if (sync_chg) begin
        db_cnt <= '0;
      end else if (db_cnt != CNT_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (!sync_chg && db_cnt == CNT_LOAD) begin
        deb <= sync2;
      end
    end
  end

  assign rise       = deb & ~deb_prev;
  assign o_key_held = |deb;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_phase;
  logic          rep_fire;
  logic          single;
  logic          vec_chg;

  assign single   = (deb != 12'd0) && ((deb & (deb - 12'd1)) == 12'd0);
  assign vec_chg  = (deb != deb_prev);
  assign rep_fire = single && !vec_chg &&
                    (rep_cnt == (rep_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1)));

  // Counting restarts on the press edge itself, so the delay is measured from the press event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (!single || vec_chg) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + 1'b1;
    end
  end

  always_comb begin
    evt      = |rise;
    evt_code = first_code(rise);
    if (!(|rise) && rep_fire) begin
      evt      = 1'b1;
      evt_code = first_code(deb);
    end
  end
`else
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_RATE;

  always_comb begin
    evt      = |rise;
    evt_code = first_code(rise);
  end
`endif

  assign full    = (count == 3'd4);
  assign pop     = key.o_key_valid & key.i_key_ready;
  assign push_ok = evt && (!full || pop);

  // When full, the write slot equals the head slot being popped this same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_key_ovf <= 1'b0;
    end else begin
      if (evt && !push_ok) begin
        o_key_ovf <= 1'b1;
      end
      if (push_ok) begin
        mem[wr_ptr] <= evt_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign key.o_key_valid = (count != 3'd0);
  assign key.o_key_code  = mem[rd_ptr];

endmodule
